// File: rtl/mac_seq_divider.sv
// Sequential restoring divider placed after the MAC accumulator.
// Divides a DIVIDEND_W-bit unsigned dividend by a DIVISOR_W-bit unsigned
// divisor and produces one quotient bit per clock. Both sides use
// valid/ready handshakes. Divide-by-zero skips the iterations and returns
// an all-ones quotient with the div_by_zero flag set.
module mac_seq_divider #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [1:0]            state_reg;
  logic [DIVIDEND_W-1:0] shift_reg;      // dividend bits out at the top, quotient bits in at the bottom
  logic [DIVISOR_W-1:0]  d_reg;          // latched divisor
  logic [DIVISOR_W-1:0]  r_reg;          // partial remainder, always < d_reg between steps
  logic [CNT_W-1:0]      cnt_reg;        // iterations still to perform
  logic [DIVIDEND_W-1:0] quotient_reg;
  logic [DIVISOR_W-1:0]  remainder_reg;
  logic                  dbz_reg;

  // The trial value carries one extra bit so the compare/subtract
  // against the divisor can never overflow.
  logic [DIVISOR_W:0]    trial_next;
  logic [DIVISOR_W:0]    d_ext;
  logic                  q_bit_next;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVIDEND_W-1:0] shift_next;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_next = {r_reg, shift_reg[DIVIDEND_W-1]};
    d_ext      = {1'b0, d_reg};
    q_bit_next = (trial_next >= d_ext);
    r_next     = q_bit_next ? DIVISOR_W'(trial_next - d_ext)
                            : trial_next[DIVISOR_W-1:0];
    shift_next = {shift_reg[DIVIDEND_W-2:0], q_bit_next};
  end

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              // No iterations needed: publish the saturated result directly.
              quotient_reg  <= '1;
              remainder_reg <= '0;
              dbz_reg       <= 1'b1;
              state_reg     <= DONE;
            end else begin
              shift_reg <= dividend;
              d_reg     <= divisor;
              r_reg     <= '0;
              cnt_reg   <= CNT_W'(DIVIDEND_W);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          shift_reg <= shift_next;
          r_reg     <= r_next;
          cnt_reg   <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            // Last step: the shift register now holds the full quotient.
            quotient_reg  <= shift_next;
            remainder_reg <= r_next;
            dbz_reg       <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mac_seq_divider.sv
// Self-checking bench for mac_seq_divider. Expected results are computed
// with the language's own / and % operators, pushed to a scoreboard queue
// when an operation is sent, and popped when the DUT raises out_valid.
module tb_mac_seq_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [33:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mac_seq_divider #(.DIVIDEND_W(34), .DIVISOR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for in_ready, push the expected result, present the operation for one edge.
  task automatic send(input logic [33:0] a, input logic [15:0] b);
    exp_t e;
    int   waited;
    logic [63:0] junk;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
    end
    if (b == 16'd0) begin
      e.q = 34'h3_FFFF_FFFF; e.r = 16'd0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = 16'(a % b); e.dbz = 1'b0; e.lat = 35;
    end
    sb.push_back(e);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    // Scramble the inputs: the DUT must have sampled them on the accept edge only.
    junk = {$urandom(), $urandom()};
    in_valid = 1'b0; dividend = junk[33:0]; divisor = junk[49:34];
  endtask

  // Wait for out_valid, compare against the scoreboard, complete handshake if out_ready.
  task automatic receive(input string name);
    exp_t e;
    int   edges;
    bit   busy_bad;
    edges = 0;
    busy_bad = 0;
    while (!out_valid && edges < 200) begin
      if (in_ready !== 1'b0) busy_bad = 1;
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue size 0 required 1", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s_busy: in_ready was 1 while busy, required 0", name);
    end
    checks++;
    if (edges + 1 != e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, edges + 1, e.lat);
    end
    checks++;
    if (quotient !== e.q) begin
      errors++;
      $display("FAIL %s_quotient: got %0d required %0d", name, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++;
      $display("FAIL %s_remainder: got %0d required %0d", name, remainder, e.r);
    end
    checks++;
    if (div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL %s_dbz: got %0b required %0b", name, div_by_zero, e.dbz);
    end
    $display("%s: result q=%0d r=%0d dbz=%0b after %0d edges", name, quotient, remainder, div_by_zero, edges + 1);
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_release: in_ready=%0b out_valid=%0b required 1/0", name, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 34'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: q=%0d r=%0d dbz=%0b required 0/0/0", quotient, remainder, div_by_zero);
    end
    $display("reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(34'd1000, 16'd7);
    receive("basic_1000_7");
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    send(34'h3_FFFF_FFFF, 16'd65535);
    receive("max_by_65535");
    send(34'h3_FFFF_FFFF, 16'd1);
    receive("max_by_1");
  endtask

  task automatic test_small();
    out_ready = 1'b1;
    send(34'd5, 16'd9);
    receive("small_5_9");
    send(34'd0, 16'd3);
    receive("zero_by_3");
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    send(34'd12345, 16'd0);
    receive("div_zero");
  endtask

  task automatic test_backpressure();
    logic [63:0] junk;
    out_ready = 1'b0;
    send(34'd1000, 16'd7);
    receive("bp_1000_7");
    for (int i = 0; i < 10; i++) begin
      junk = {$urandom(), $urandom()};
      in_valid = junk[60]; dividend = junk[33:0]; divisor = junk[49:34];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 34'd142 ||
          remainder !== 16'd6 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: ov=%0b ir=%0b q=%0d r=%0d dbz=%0b required 1/0/142/6/0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
    end
    // in_valid stays high across the output handshake edge: it must not be taken.
    in_valid = 1'b1; dividend = 34'd50; divisor = 16'd5;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept_on_handshake: in_ready=%0b required 1", in_ready);
    end
    $display("backpressure: held 10 cycles, released");
  endtask

  task automatic test_reset_mid_op();
    bit late;
    out_ready = 1'b1;
    send(34'd1000, 16'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 34'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: q=%0d r=%0d dbz=%0b required 0/0/0", quotient, remainder, div_by_zero);
    end
    late = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) late = 1;
    end
    checks++;
    if (late) begin
      errors++;
      $display("FAIL midrst_late_result: out_valid seen 1 required 0");
    end
    $display("reset_mid_op: operation discarded");
    send(34'd100, 16'd10);
    receive("after_rst_100_10");
  endtask

  task automatic test_back_to_back();
    logic [63:0] junk;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      junk = {$urandom(), $urandom()};
      if (i == 3) junk[49:34] = 16'd0;
      send(junk[33:0], junk[49:34]);
      receive($sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_small();
    test_div_zero();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
